// File: rtl/timer_counter_if.sv
// CPU data-bus port of the countdown timer: address, byte-enabled write data,
// combinational read data and the registered interrupt request.
interface timer_counter_if;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output addr,
    output byteen,
    output wdata,
    input  rdata,
    input  irq
  );

  modport slave (
    input  addr,
    input  byteen,
    input  wdata,
    output rdata,
    output irq
  );
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes and a
// maskable, registered interrupt line.
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic             clk,
  input  logic             reset,
  timer_counter_if.slave   bus
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t              state,  state_nxt;
  logic                en,     en_nxt;
  logic [1:0]          mode,   mode_nxt;
  logic                im,     im_nxt;
  logic [DATA_W-1:0]   preset, preset_nxt;
  logic [DATA_W-1:0]   count,  count_nxt;
  logic                flag,   flag_nxt;
  logic                irq_q,  irq_nxt;

  logic                hit;
  logic [1:0]          sel;
  logic                wr_ctrl;
  logic                wr_preset;
  logic                unused_addr_bits;

  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] cur,
    input logic [DATA_W-1:0] din,
    input logic [3:0]        be
  );
    logic [DATA_W-1:0] merged;
    merged = cur;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) merged[8*k +: 8] = din[8*k +: 8];
    end
    return merged;
  endfunction

  assign hit              = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign sel              = bus.addr[3:2];
  assign wr_ctrl          = hit && (bus.byteen != 4'd0) && (sel == 2'd0);
  assign wr_preset        = hit && (bus.byteen != 4'd0) && (sel == 2'd1);
  assign unused_addr_bits = ^bus.addr[1:0];

  always_comb begin
    bus.rdata = '0;
    if (hit) begin
      case (sel)
        2'd0:    bus.rdata = {28'd0, im, mode, en};
        2'd1:    bus.rdata = preset;
        2'd2:    bus.rdata = count;
        default: bus.rdata = '0;
      endcase
    end
  end

  // Next-state: FSM decisions use pre-edge values, then CPU writes override.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    en_nxt     = en;
    mode_nxt   = mode;
    im_nxt     = im;
    preset_nxt = preset;
    flag_nxt   = flag;

    case (state)
      IDLE: begin
        if (en) state_nxt = LOAD;
      end
      LOAD: begin
        count_nxt = preset;
        flag_nxt  = 1'b0;
        state_nxt = CNT;
      end
      CNT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (count == '0) begin
          state_nxt = INT;
          flag_nxt  = 1'b1;
        end else begin
          count_nxt = count - 32'd1;
        end
      end
      INT: begin
        if (mode == 2'd1) flag_nxt = 1'b0;
        else              en_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (wr_ctrl && bus.byteen[0]) {im_nxt, mode_nxt, en_nxt} = bus.wdata[3:0];
    if (wr_preset) preset_nxt = lane_merge(preset, bus.wdata, bus.byteen);
    // A register write beats a same-edge flag set.
    if (wr_ctrl || wr_preset) flag_nxt = 1'b0;

    // Registered from post-edge values so irq follows the flag without a lag cycle.
    irq_nxt = flag_nxt & im_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      en     <= 1'b0;
      mode   <= 2'd0;
      im     <= 1'b0;
      preset <= '0;
      count  <= '0;
      flag   <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      en     <= en_nxt;
      mode   <= mode_nxt;
      im     <= im_nxt;
      preset <= preset_nxt;
      count  <= count_nxt;
      flag   <= flag_nxt;
      irq_q  <= irq_nxt;
    end
  end

  assign bus.irq = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: stimulus queues expected read data and irq,
// a negedge monitor pops and compares against the bus.
module tb_timer_counter;

  localparam logic [31:0] BASE = 32'h0000_7F00;

  typedef struct {
    string       name;
    bit          is_irq;
    logic [31:0] exp;
  } item_t;

  logic clk = 1'b0;
  logic reset;

  timer_counter_if bus();

  timer_counter #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  item_t       sb[$];
  item_t       cur;
  logic [31:0] act;
  int          compared   = 0;
  int          mismatched = 0;

  // One-shot, PRESET=5, CTRL=0x9: step k samples state after edge N+k.
  localparam logic [7:0]  T2_OFF [11] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08,
                                          8'h08, 8'h08, 8'h00, 8'h00, 8'h08};
  localparam logic [31:0] T2_EXP [11] = '{0, 0, 5, 4, 3, 2, 1, 0, 32'h9, 32'h8, 0};
  localparam logic [10:0] T2_IRQ = (11'd1 << 8) | (11'd1 << 9) | (11'd1 << 10);

  // Auto-reload, PRESET=3, CTRL=0xB: COUNT over two and a half periods.
  localparam logic [31:0] T3_EXP [17] = '{0, 0, 3, 2, 1, 0, 0, 0, 0, 3, 2, 1, 0, 0, 0, 0, 3};
  localparam logic [16:0] T3_IRQ = (17'd1 << 6) | (17'd1 << 13);

  // Masked one-shot, PRESET=2, CTRL=0x1.
  localparam logic [7:0]  T4_OFF [8] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00};
  localparam logic [31:0] T4_EXP [8] = '{1, 1, 2, 1, 0, 1, 0, 0};

  // One-shot with PRESET=0.
  localparam logic [7:0]  T6_OFF [5] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00};
  localparam logic [31:0] T6_EXP [5] = '{0, 0, 0, 0, 32'h8};
  localparam logic [4:0]  T6_IRQ = (5'd1 << 3) | (5'd1 << 4);

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      act = cur.is_irq ? {31'd0, bus.irq} : bus.rdata;
      compared++;
      if (act !== cur.exp) begin
        mismatched++;
        $display("FAIL %s: got %h, expected %h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] off, input logic [3:0] be, input logic [31:0] d);
    bus.addr   = BASE + {24'd0, off};
    bus.byteen = be;
    bus.wdata  = d;
    tick();
    bus.byteen = 4'd0;
  endtask

  task automatic chk(input string name, input logic [7:0] off, input logic [31:0] exp,
                     input logic exp_irq);
    item_t it;
    bus.addr   = BASE + {24'd0, off};
    bus.byteen = 4'd0;
    it.name   = name;
    it.is_irq = 1'b0;
    it.exp    = exp;
    sb.push_back(it);
    it.name   = {name, ".irq"};
    it.is_irq = 1'b1;
    it.exp    = {31'd0, exp_irq};
    sb.push_back(it);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 1000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    bus.addr   = BASE;
    bus.byteen = 4'd0;
    bus.wdata  = 32'd0;
    tick();
    tick();
    reset = 1'b0;

    bus.addr = BASE + 32'h8;
    #1;
    compared++;
    if (bus.rdata !== 32'h0) begin
      mismatched++;
      $display("FAIL direct.rst.count: got %h, expected %h", bus.rdata, 32'h0);
    end
    compared++;
    if (bus.irq !== 1'b0) begin
      mismatched++;
      $display("FAIL direct.rst.irq: got %b, expected 0", bus.irq);
    end

    chk("rst.ctrl",   8'h00, 32'h0, 1'b0);
    chk("rst.preset", 8'h04, 32'h0, 1'b0);
    chk("rst.count",  8'h08, 32'h0, 1'b0);
    chk("rst.regc",   8'h0C, 32'h0, 1'b0);
    chk("rst.nohit",  8'h10, 32'h0, 1'b0);

    wr(8'h04, 4'hF, 32'd5);
    wr(8'h00, 4'hF, 32'h9);
    for (int k = 0; k < 11; k++)
      chk($sformatf("oneshot.k%0d", k), T2_OFF[k], T2_EXP[k], T2_IRQ[k]);
    chk("oneshot.ctrl_late", 8'h00, 32'h8, 1'b1);
    wr(8'h00, 4'hF, 32'h0);
    chk("oneshot.cleared", 8'h00, 32'h0, 1'b0);

    wr(8'h04, 4'hF, 32'd3);
    wr(8'h00, 4'hF, 32'hB);
    for (int k = 0; k < 17; k++)
      chk($sformatf("reload.k%0d", k), 8'h08, T3_EXP[k], T3_IRQ[k]);
    wr(8'h00, 4'hF, 32'h0);
    chk("reload.stop0", 8'h08, 32'd1, 1'b0);
    chk("reload.stop1", 8'h08, 32'd1, 1'b0);

    wr(8'h04, 4'hF, 32'd2);
    wr(8'h00, 4'hF, 32'h1);
    for (int k = 0; k < 8; k++)
      chk($sformatf("masked.k%0d", k), T4_OFF[k], T4_EXP[k], 1'b0);

    wr(8'h04, 4'hF, 32'h1234_5678);
    chk("lane.full", 8'h04, 32'h1234_5678, 1'b0);
    wr(8'h04, 4'b0001, 32'hFFFF_FFFF);
    chk("lane.b0", 8'h04, 32'h1234_56FF, 1'b0);
    wr(8'h04, 4'b0100, 32'h00AB_0000);
    chk("lane.b2", 8'h04, 32'h12AB_56FF, 1'b0);
    wr(8'h0C, 4'hF, 32'hFFFF_FFFF);
    chk("lane.regc", 8'h0C, 32'h0, 1'b0);
    wr(8'h14, 4'hF, 32'h0);
    chk("lane.nohit_wr", 8'h04, 32'h12AB_56FF, 1'b0);
    chk("lane.lowbits",  8'h05, 32'h12AB_56FF, 1'b0);

    wr(8'h04, 4'hF, 32'd0);
    wr(8'h00, 4'hF, 32'h9);
    for (int k = 0; k < 5; k++)
      chk($sformatf("p0.k%0d", k), T6_OFF[k], T6_EXP[k], T6_IRQ[k]);
    wr(8'h04, 4'hF, 32'd6);
    chk("p0.preset_clears", 8'h04, 32'd6, 1'b0);

    wr(8'h00, 4'hF, 32'h1);
    chk("mid.k0", 8'h08, 32'd0, 1'b0);
    chk("mid.k1", 8'h08, 32'd0, 1'b0);
    chk("mid.k2", 8'h08, 32'd6, 1'b0);
    wr(8'h00, 4'hF, 32'h0);
    chk("mid.stop", 8'h08, 32'd4, 1'b0);
    wr(8'h08, 4'hF, 32'hFFFF_FFFF);
    chk("mid.hold",   8'h08, 32'd4, 1'b0);
    chk("mid.ctrl",   8'h00, 32'h0, 1'b0);
    wr(8'h00, 4'hF, 32'h1);
    chk("mid.re_k0", 8'h08, 32'd4, 1'b0);
    chk("mid.re_k1", 8'h08, 32'd4, 1'b0);
    chk("mid.re_k2", 8'h08, 32'd6, 1'b0);
    chk("mid.re_k3", 8'h08, 32'd5, 1'b0);

    reset = 1'b1;
    tick();
    reset = 1'b0;

    bus.addr = BASE;
    #1;
    compared++;
    if (bus.rdata !== 32'h0) begin
      mismatched++;
      $display("FAIL direct.mrst.ctrl: got %h, expected %h", bus.rdata, 32'h0);
    end
    compared++;
    if (bus.irq !== 1'b0) begin
      mismatched++;
      $display("FAIL direct.mrst.irq: got %b, expected 0", bus.irq);
    end

    chk("mrst.ctrl",   8'h00, 32'h0, 1'b0);
    chk("mrst.preset", 8'h04, 32'h0, 1'b0);
    chk("mrst.count",  8'h08, 32'h0, 1'b0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    if (mismatched != 0)
      $display("FAIL: %0d mismatches", mismatched);
    else
      $display("PASS");
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped countdown timer that sits on the CPU data bus as a responder: it decodes the CPU's data address, write-data and byte enables, returns read data, and drives the interrupt line that the CPU samples as its external `interrupt` input. It supports a one-shot mode and an auto-reload mode. Each mode has a maskable interrupt. It is the first peripheral behind the data-memory address space.

## Interface
- `BASE_ADDR`, default 32'h0000_7F00, 16-byte-aligned base of the register window.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `addr`  in  32  CPU data address (m_data_addr).
- `byteen`  in  4  per-byte write enables (m_data_byteen); nonzero means write.
- `wdata`  in  32  write data, lane-aligned (m_data_wdata).
- `rdata`  out  32  combinational read data for `addr`.
- `irq`  out  1  interrupt request to CPU, registered.

## Operation
- Hit: `addr[31:4] == BASE_ADDR[31:4]`; `addr[1:0]` ignored; `addr[3:2]` selects register.
- Registers:
  - +0 CTRL, RW: bit0 EN, bits2:1 MODE, bit3 IM; other bits read 0.
  - +4 PRESET, RW, 32 bits.
  - +8 COUNT, RO; writes ignored.
  - +C: reads 0, writes ignored.
- Writes merge per byte lane: lane k is updated only when `byteen[k]`.
- MODE 0 = one-shot and MODE 1 = auto-reload. MODE 2 and 3 behave as MODE 0.
- `rdata` is the selected register. Non-hit addresses return 0.
- Internal IRQ flag; `irq = flag & IM`, registered.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT <= PRESET, flag <= 0 -> CNT.
  - CNT:
    - EN=0 -> IDLE, COUNT held.
    - Otherwise COUNT==0 -> INT, flag <= 1.
    - Otherwise COUNT <= COUNT-1.
  - INT:
    - MODE 0: EN <= 0 -> IDLE, flag held.
    - MODE 1: flag <= 0 -> IDLE. IDLE then reloads on the next edge.
- Any write to CTRL or PRESET clears the flag at that edge.
- Simultaneous events:
  - FSM transitions use pre-edge register values.
  - A CPU write to CTRL overrides the INT-state EN clear at the same edge.
  - A PRESET write during CNT does not affect COUNT until the next LOAD.
  - Flag set (CNT->INT) and a CTRL/PRESET write in the same edge: the write wins and the flag stays 0.
- Decrement is unsigned 32-bit. COUNT never wraps, because 0 exits CNT.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, flag=0, `irq`=0.
- `rdata` reflects register state after each edge, with zero read latency.
- Full sequence with PRESET=P and EN set by a CTRL write at edge N:
  - IDLE at N.
  - LOAD at N+1.
  - CNT with COUNT=P at N+2.
  - COUNT=0 at N+P+2.
  - INT at N+P+3, flag set. `irq` is high after edge N+P+3 if IM=1.
- P=0: INT after edge N+3.
- MODE 0: `irq` stays high until a CTRL/PRESET write or reset. CTRL.EN reads 0 from edge N+P+4.
- MODE 1: `irq` high for exactly one cycle (N+P+3 to N+P+4). Then LOAD at N+P+5 and CNT=P at N+P+6, giving a period of P+4 cycles.
- Reset mid-operation: all state returns to reset values at that edge, and `irq` drops immediately after it.

## Test plan
- Reset, then read +0/+4/+8 -> all 0; `irq`=0; read BASE+0x10 -> 0.
- PRESET<=5, then CTRL<=0x9 at edge N:
  - `irq` rises after edge N+8 and stays high.
  - CTRL reads 0x8 from N+9.
  - CTRL<=0 clears `irq` after that edge.
- PRESET<=3, CTRL<=0xB: `irq` one-cycle pulses every 7 cycles. COUNT reads 3,2,1,0 in each period.
- IM=0 (CTRL<=0x1, PRESET<=2): `irq` never rises; COUNT reaches 0; CTRL reads 0x0 afterwards.
- PRESET=0x12345678, write 0xFFFFFFFF with `byteen`=4'b0001 -> PRESET reads 0x123456FF. Writing COUNT does not change it.
- Mid-count:
  - CTRL<=0 during CNT with COUNT=4 -> IDLE next edge, COUNT holds 4.
  - Re-enable -> reload from PRESET.
  - Separately, `reset` mid-count -> all registers 0 and `irq` 0.
